// File: rtl/gemm_task_scheduler_pkg.sv
// gemm_task_scheduler_pkg: shared state encoding, error bit positions and descriptor layout.
package gemm_task_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_STREAM,
        ST_DRAIN,
        ST_FIN
    } state_e;

    localparam int ERR_EARLY_LAST   = 0;
    localparam int ERR_LEN_MISMATCH = 1;
    localparam int ERR_TIMEOUT      = 2;

    typedef struct packed {
        logic        switch_conv;
        logic [15:0] out_ch;
        logic [15:0] w_row;
        logic [15:0] out_col;
        logic [15:0] out_row;
        logic [15:0] gemm_w;
        logic [15:0] gemm_h;
    } geom_t;

    localparam int GEOM_W = $bits(geom_t);

    // FIFO entry = geometry followed by input and output beat counts
    function automatic int desc_w(input int cnt_w);
        return GEOM_W + 2 * cnt_w;
    endfunction

endpackage

// File: rtl/gemm_task_scheduler_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty flags.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, empty_q, do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;
    assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign dout_o  = mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q   <= cnt_d;
            full_q  <= cnt_d == (AW+1)'(DEPTH);
            empty_q <= cnt_d == '0;
        end
    end
endmodule

// File: rtl/gemm_task_scheduler.sv
// gemm_task_scheduler: queues GEMM/conv layer descriptors, starts the unit, gates its input
// stream to the expected beat count and polices the output stream length.
module gemm_task_scheduler
    import gemm_task_scheduler_pkg::*;
#(
    parameter int DESC_DEPTH = 4,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             desc_valid,
    output logic             desc_ready,
    input  logic             desc_switch_conv,
    input  logic [15:0]      desc_out_ch,
    input  logic [15:0]      desc_w_row,
    input  logic [15:0]      desc_out_col,
    input  logic [15:0]      desc_out_row,
    input  logic [15:0]      desc_gemm_w,
    input  logic [15:0]      desc_gemm_h,
    input  logic [CNT_W-1:0] desc_in_beats,
    input  logic [CNT_W-1:0] desc_out_beats,
    output logic             cfg_switch_conv,
    output logic [15:0]      cfg_out_ch,
    output logic [15:0]      cfg_w_row,
    output logic [15:0]      cfg_out_col,
    output logic [15:0]      cfg_out_row,
    output logic [15:0]      cfg_gemm_w,
    output logic [15:0]      cfg_gemm_h,
    output logic [CNT_W-1:0] cfg_in_beats,
    output logic [CNT_W-1:0] cfg_out_beats,
    output logic             unit_start,
    input  logic             src_tvalid,
    output logic             src_tready,
    output logic             unit_tvalid,
    input  logic             unit_tready,
    input  logic             out_tvalid,
    input  logic             out_tready,
    input  logic             out_tlast,
    output logic             busy,
    output logic             done,
    output logic [2:0]       err,
    input  logic             err_clr
);
    localparam int DW = desc_w(CNT_W);

    state_e           state_q;
    geom_t            geom_in, fifo_geom, cfg_q;
    logic [DW-1:0]    fifo_dout;
    logic [CNT_W-1:0] fifo_in, fifo_out;
    logic [CNT_W-1:0] in_beats_q, out_beats_q, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, out_inc;
    logic [31:0]      wd_q, wd_d;
    logic [2:0]       err_q, new_err;
    logic             fifo_full, fifo_empty, gate, in_hs, out_hs, last_hs, wd_fire;
    logic             start_q, done_q, busy_q;

    assign geom_in = {desc_switch_conv, desc_out_ch, desc_w_row, desc_out_col,
                      desc_out_row, desc_gemm_w, desc_gemm_h};
    assign {fifo_geom, fifo_in, fifo_out} = fifo_dout;

    sync_fifo #(.W(DW), .DEPTH(DESC_DEPTH)) u_desc_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (desc_valid),
        .din_i  ({geom_in, desc_in_beats, desc_out_beats}),
        .pop_i  (state_q == ST_LOAD),
        .dout_o (fifo_dout),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    // Gate stays shut once the expected input count is reached, so no extra beat can slip through
    assign gate        = state_q == ST_STREAM && in_cnt_q != in_beats_q;
    assign unit_tvalid = gate && src_tvalid;
    assign src_tready  = gate && unit_tready;
    assign in_hs       = unit_tvalid && unit_tready;
    assign out_hs      = out_tvalid && out_tready;
    assign last_hs     = out_hs && out_tlast;

    assign out_inc   = &out_cnt_q ? out_cnt_q : out_cnt_q + 1'b1;
    assign in_cnt_d  = state_q == ST_START ? '0 :
                       (in_hs && !(&in_cnt_q)) ? in_cnt_q + 1'b1 : in_cnt_q;
    assign out_cnt_d = state_q == ST_START ? '0 :
                       (out_hs && (state_q == ST_STREAM || state_q == ST_DRAIN)) ? out_inc : out_cnt_q;
    assign wd_d      = (state_q != ST_DRAIN || out_hs) ? '0 : wd_q + 1'b1;
    assign wd_fire   = TIMEOUT > 0 && state_q == ST_DRAIN && !out_hs && wd_q == 32'(TIMEOUT - 1);

    assign new_err[ERR_EARLY_LAST]   = state_q == ST_STREAM && last_hs;
    assign new_err[ERR_LEN_MISMATCH] = state_q == ST_DRAIN && last_hs && out_inc != out_beats_q;
    assign new_err[ERR_TIMEOUT]      = wd_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            in_beats_q  <= '0;
            out_beats_q <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            wd_q        <= '0;
            err_q       <= '0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            err_q     <= (err_clr ? 3'b000 : err_q) | new_err;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            wd_q      <= wd_d;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: if (!fifo_empty) begin
                    state_q <= ST_LOAD;
                    busy_q  <= 1'b1;
                end
                ST_LOAD: begin
                    cfg_q       <= fifo_geom;
                    in_beats_q  <= fifo_in;
                    out_beats_q <= fifo_out;
                    state_q     <= ST_START;
                    start_q     <= 1'b1;
                end
                ST_START: state_q <= ST_STREAM;
                ST_STREAM: if (last_hs) begin
                    state_q <= ST_FIN;
                    done_q  <= 1'b1;
                end else if (in_cnt_d == in_beats_q) begin
                    state_q <= ST_DRAIN;
                end
                ST_DRAIN: if (last_hs || wd_fire) begin
                    state_q <= ST_FIN;
                    done_q  <= 1'b1;
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign desc_ready      = !fifo_full;
    assign unit_start      = start_q;
    assign done            = done_q;
    assign busy            = busy_q;
    assign err             = err_q;
    assign cfg_switch_conv = cfg_q.switch_conv;
    assign cfg_out_ch      = cfg_q.out_ch;
    assign cfg_w_row       = cfg_q.w_row;
    assign cfg_out_col     = cfg_q.out_col;
    assign cfg_out_row     = cfg_q.out_row;
    assign cfg_gemm_w      = cfg_q.gemm_w;
    assign cfg_gemm_h      = cfg_q.gemm_h;
    assign cfg_in_beats    = in_beats_q;
    assign cfg_out_beats   = out_beats_q;
endmodule

// File: tb/tb_gemm_task_scheduler.sv
// tb_gemm_task_scheduler: directed scenarios for the GEMM task scheduler with hand-computed expectations.
module tb_gemm_task_scheduler;
    logic        clk = 1'b0;
    logic        reset, desc_valid, desc_ready, desc_switch_conv;
    logic [15:0] desc_out_ch, desc_w_row, desc_out_col, desc_out_row, desc_gemm_w, desc_gemm_h;
    logic [31:0] desc_in_beats, desc_out_beats;
    logic        cfg_switch_conv;
    logic [15:0] cfg_out_ch, cfg_w_row, cfg_out_col, cfg_out_row, cfg_gemm_w, cfg_gemm_h;
    logic [31:0] cfg_in_beats, cfg_out_beats;
    logic        unit_start, src_tvalid, src_tready, unit_tvalid, unit_tready;
    logic        out_tvalid, out_tready, out_tlast, busy, done, err_clr;
    logic [2:0]  err;

    int checks = 0;
    int errors = 0;
    int mon_in, mon_start, mon_done;
    logic mon_clr = 1'b0;
    logic [15:0] start_log[$];
    logic [15:0] done_log[$];

    always #5 clk = ~clk;

    gemm_task_scheduler #(.DESC_DEPTH(4), .CNT_W(32), .TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_switch_conv(desc_switch_conv), .desc_out_ch(desc_out_ch), .desc_w_row(desc_w_row),
        .desc_out_col(desc_out_col), .desc_out_row(desc_out_row), .desc_gemm_w(desc_gemm_w),
        .desc_gemm_h(desc_gemm_h), .desc_in_beats(desc_in_beats), .desc_out_beats(desc_out_beats),
        .cfg_switch_conv(cfg_switch_conv), .cfg_out_ch(cfg_out_ch), .cfg_w_row(cfg_w_row),
        .cfg_out_col(cfg_out_col), .cfg_out_row(cfg_out_row), .cfg_gemm_w(cfg_gemm_w),
        .cfg_gemm_h(cfg_gemm_h), .cfg_in_beats(cfg_in_beats), .cfg_out_beats(cfg_out_beats),
        .unit_start(unit_start), .src_tvalid(src_tvalid), .src_tready(src_tready),
        .unit_tvalid(unit_tvalid), .unit_tready(unit_tready), .out_tvalid(out_tvalid),
        .out_tready(out_tready), .out_tlast(out_tlast), .busy(busy), .done(done), .err(err),
        .err_clr(err_clr)
    );

    // Handshakes are counted mid-cycle, when the gate and valid/ready are stable
    always @(negedge clk) begin
        if (mon_clr) begin
            mon_in = 0; mon_start = 0; mon_done = 0;
            start_log.delete(); done_log.delete();
        end else begin
            if (unit_tvalid && unit_tready) mon_in++;
            if (unit_start) begin mon_start++; start_log.push_back(cfg_out_ch); end
            if (done) begin mon_done++; done_log.push_back(cfg_out_ch); end
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1; @(negedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic push(input logic [31:0] ib, input logic [31:0] ob, input logic [15:0] ch);
        @(posedge clk); #1;
        desc_valid = 1'b1; desc_in_beats = ib; desc_out_beats = ob; desc_out_ch = ch;
        desc_gemm_w = ch + 16'd1; desc_gemm_h = ch + 16'd2;
        @(posedge clk); #1 desc_valid = 1'b0;
    endtask

    task automatic emit(input int n, input int last_at);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1 out_tvalid = 1'b1; out_tlast = (i == last_at);
        end
        @(posedge clk); #1 out_tvalid = 1'b0; out_tlast = 1'b0;
    endtask

    task automatic pulse_err_clr();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; src_tvalid = 1'b1; unit_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0h exp 0", done); end
        checks++; if (unit_start !== 1'b0) begin errors++; $display("FAIL reset_start got %0h exp 0", unit_start); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL reset_err got %0h exp 0", err); end
        checks++; if (desc_ready !== 1'b1) begin errors++; $display("FAIL reset_desc_ready got %0h exp 1", desc_ready); end
        checks++; if (unit_tvalid !== 1'b0) begin errors++; $display("FAIL reset_unit_tvalid got %0h exp 0", unit_tvalid); end
        checks++; if (src_tready !== 1'b0) begin errors++; $display("FAIL reset_src_tready got %0h exp 0", src_tready); end
        checks++; if (cfg_out_ch !== 16'h0) begin errors++; $display("FAIL reset_cfg got %0h exp 0", cfg_out_ch); end
    endtask

    task automatic test_gemm();
        int first;
        first = 0;
        clear_mon();
        src_tvalid = 1'b1;
        push(102, 23, 16'h0123);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (unit_start && first == 0) first = k;
        end
        checks++; if (first !== 3) begin errors++; $display("FAIL gemm_start_latency got %0d exp 3", first); end
        checks++; if (cfg_out_ch !== 16'h0123) begin errors++; $display("FAIL gemm_cfg_out_ch got %0h exp 123", cfg_out_ch); end
        checks++; if (cfg_gemm_h !== 16'h0125) begin errors++; $display("FAIL gemm_cfg_gemm_h got %0h exp 125", cfg_gemm_h); end
        checks++; if (cfg_in_beats !== 32'd102) begin errors++; $display("FAIL gemm_cfg_in_beats got %0d exp 102", cfg_in_beats); end
        for (int i = 0; i < 300 && mon_in < 102; i++) step();
        emit(23, 23);
        for (int i = 0; i < 20 && mon_done < 1; i++) step();
        repeat (3) step();
        checks++; if (mon_in !== 102) begin errors++; $display("FAIL gemm_in_beats got %0d exp 102", mon_in); end
        checks++; if (mon_start !== 1) begin errors++; $display("FAIL gemm_start_pulses got %0d exp 1", mon_start); end
        checks++; if (mon_done !== 1) begin errors++; $display("FAIL gemm_done_pulses got %0d exp 1", mon_done); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL gemm_err got %0h exp 0", err); end
        checks++; if (unit_tvalid !== 1'b0) begin errors++; $display("FAIL gemm_gate_closed got %0h exp 0", unit_tvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gemm_busy_after got %0h exp 0", busy); end
    endtask

    task automatic test_len_mismatch();
        clear_mon();
        push(4, 23, 16'h0200);
        for (int i = 0; i < 50 && mon_in < 4; i++) step();
        emit(20, 20);
        for (int i = 0; i < 20 && mon_done < 1; i++) step();
        repeat (3) step();
        checks++; if (err !== 3'b010) begin errors++; $display("FAIL len_err got %0h exp 2", err); end
        checks++; if (mon_done !== 1) begin errors++; $display("FAIL len_done_pulses got %0d exp 1", mon_done); end
        repeat (5) step();
        checks++; if (err !== 3'b010) begin errors++; $display("FAIL len_err_sticky got %0h exp 2", err); end
        pulse_err_clr();
        step();
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL len_err_clr got %0h exp 0", err); end
    endtask

    task automatic test_early_last();
        clear_mon();
        src_tvalid = 1'b0;
        push(100, 10, 16'h0300);
        for (int i = 0; i < 20 && !unit_start; i++) step();
        @(posedge clk); #1 src_tvalid = 1'b1;
        repeat (50) @(posedge clk);
        #1 src_tvalid = 1'b0;
        emit(1, 1);
        src_tvalid = 1'b1;
        for (int i = 0; i < 20 && mon_done < 1; i++) step();
        repeat (3) step();
        checks++; if (mon_in !== 50) begin errors++; $display("FAIL early_in_beats got %0d exp 50", mon_in); end
        checks++; if (err !== 3'b001) begin errors++; $display("FAIL early_err got %0h exp 1", err); end
        checks++; if (mon_done !== 1) begin errors++; $display("FAIL early_done_pulses got %0d exp 1", mon_done); end
        checks++; if (unit_tvalid !== 1'b0) begin errors++; $display("FAIL early_unit_tvalid got %0h exp 0", unit_tvalid); end
        checks++; if (src_tready !== 1'b0) begin errors++; $display("FAIL early_src_tready got %0h exp 0", src_tready); end
        pulse_err_clr();
    endtask

    task automatic test_zero_beats();
        clear_mon();
        src_tvalid = 1'b1;
        push(0, 1, 16'h0400);
        for (int i = 0; i < 20 && !unit_start; i++) step();
        repeat (4) step();
        checks++; if (unit_tvalid !== 1'b0) begin errors++; $display("FAIL zero_gate got %0h exp 0", unit_tvalid); end
        emit(1, 1);
        for (int i = 0; i < 20 && mon_done < 1; i++) step();
        checks++; if (mon_in !== 0) begin errors++; $display("FAIL zero_in_beats got %0d exp 0", mon_in); end
        checks++; if (mon_done !== 1) begin errors++; $display("FAIL zero_done_pulses got %0d exp 1", mon_done); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL zero_err got %0h exp 0", err); end
    endtask

    task automatic test_timeout();
        clear_mon();
        src_tvalid = 1'b1;
        push(5, 3, 16'h0500);
        for (int i = 0; i < 30 && mon_in < 5; i++) step();
        repeat (100) step();
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL timeout_early_err got %0h exp 0", err); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL timeout_early_done got %0h exp 0", done); end
        step();
        checks++; if (err !== 3'b100) begin errors++; $display("FAIL timeout_err got %0h exp 4", err); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL timeout_done got %0h exp 1", done); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL timeout_done_width got %0h exp 0", done); end
        pulse_err_clr();
    endtask

    task automatic test_back_to_back();
        clear_mon();
        src_tvalid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            desc_valid = 1'b1; desc_in_beats = 2; desc_out_beats = 1;
            desc_out_ch = 16'(10 + i); desc_gemm_w = 16'(20 + i); desc_gemm_h = 16'(30 + i);
            @(posedge clk); #1;
        end
        checks++; if (desc_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %0h exp 0", desc_ready); end
        desc_out_ch = 16'd99;
        @(posedge clk); #1 desc_valid = 1'b0;
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 40 && mon_start <= t; i++) step();
            for (int i = 0; i < 40 && mon_in < 2 * (t + 1); i++) step();
            emit(1, 1);
            for (int i = 0; i < 20 && mon_done <= t; i++) step();
        end
        repeat (10) step();
        checks++; if (mon_start !== 5) begin errors++; $display("FAIL b2b_starts got %0d exp 5", mon_start); end
        checks++; if (mon_done !== 5) begin errors++; $display("FAIL b2b_dones got %0d exp 5", mon_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %0h exp 0", busy); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL b2b_err got %0h exp 0", err); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= start_log.size() || start_log[i] !== 16'(10 + i)) begin
                errors++; $display("FAIL b2b_start_cfg%0d got %0h exp %0h", i, (i < start_log.size()) ? start_log[i] : 16'hffff, 10 + i);
            end
            checks++;
            if (i >= done_log.size() || done_log[i] !== 16'(10 + i)) begin
                errors++; $display("FAIL b2b_done_cfg%0d got %0h exp %0h", i, (i < done_log.size()) ? done_log[i] : 16'hffff, 10 + i);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        src_tvalid = 1'b1;
        push(100, 5, 16'h0600);
        for (int i = 0; i < 60 && mon_in < 40; i++) step();
        reset = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0h exp 0", busy); end
        checks++; if (unit_start !== 1'b0) begin errors++; $display("FAIL rmid_start got %0h exp 0", unit_start); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %0h exp 0", done); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL rmid_err got %0h exp 0", err); end
        checks++; if (unit_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_unit_tvalid got %0h exp 0", unit_tvalid); end
        checks++; if (src_tready !== 1'b0) begin errors++; $display("FAIL rmid_src_tready got %0h exp 0", src_tready); end
        checks++; if (desc_ready !== 1'b1) begin errors++; $display("FAIL rmid_desc_ready got %0h exp 1", desc_ready); end
        checks++; if (cfg_out_ch !== 16'h0) begin errors++; $display("FAIL rmid_cfg got %0h exp 0", cfg_out_ch); end
        reset = 1'b0;
        repeat (5) step();
        checks++; if (mon_done !== 0) begin errors++; $display("FAIL rmid_no_done got %0d exp 0", mon_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_fifo_empty got %0h exp 0", busy); end
    endtask

    initial begin
        reset = 1'b1; desc_valid = 1'b0; desc_switch_conv = 1'b0;
        desc_out_ch = '0; desc_w_row = 16'd3; desc_out_col = 16'd7; desc_out_row = 16'd7;
        desc_gemm_w = '0; desc_gemm_h = '0; desc_in_beats = '0; desc_out_beats = '0;
        src_tvalid = 1'b0; unit_tready = 1'b1; out_tvalid = 1'b0; out_tready = 1'b1;
        out_tlast = 1'b0; err_clr = 1'b0;
        test_reset();
        test_gemm();
        test_len_mismatch();
        test_early_last();
        test_zero_beats();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
